// File: rtl/phyf_wb_arbiter_pkg.sv
// rtl/phyf_wb_arbiter_pkg.sv - shared widths and index helper for the writeback arbiter
package phyf_wb_arbiter_pkg;

  localparam int WB_WIDTH         = 4;
  localparam int PHY_REG_ID_WIDTH = 7;
  localparam int REG_DATA_WIDTH   = 32;
  localparam int EXU_NUM_DEF      = 6;

  localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

  // Modular add used to move between rotated and absolute requester indices.
  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/phyf_wb_arbiter_picker.sv
// rtl/phyf_wb_arbiter_picker.sv - picks the first W valid entries of a rotated request vector
module wb_rr_picker #(
  parameter int N     = 6,
  parameter int W     = 4,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]            rot_valid,
  output logic [N-1:0]            grant_rot,
  output logic [W-1:0][PTR_W-1:0] slot_idx,
  output logic [W-1:0]            slot_used,
  output logic [PTR_W-1:0]        last_idx
);

  int used_cnt;

  // Walk the rotated vector; the k-th valid entry found lands in slot k.
  always_comb begin
    grant_rot = '0;
    slot_idx  = '0;
    slot_used = '0;
    last_idx  = '0;
    used_cnt  = 0;
    for (int j = 0; j < N; j++) begin
      if (rot_valid[j] && (used_cnt < W)) begin
        grant_rot[j]       = 1'b1;
        slot_idx[used_cnt] = PTR_W'(j);
        slot_used[used_cnt] = 1'b1;
        last_idx           = PTR_W'(j);
        used_cnt           = used_cnt + 1;
      end
    end
  end

endmodule

// File: rtl/phyf_wb_arbiter.sv
// rtl/phyf_wb_arbiter.sv - round-robin share of regfile write ports among execution units
module phyf_wb_arbiter
  import phyf_wb_arbiter_pkg::*;
#(
  parameter int EXU_NUM = EXU_NUM_DEF
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [EXU_NUM-1:0]                        exu_wb_valid,
  input  logic [EXU_NUM-1:0][PHY_REG_ID_WIDTH-1:0]  exu_wb_id,
  input  logic [EXU_NUM-1:0][REG_DATA_WIDTH-1:0]    exu_wb_data,
  output logic [EXU_NUM-1:0]                        exu_wb_ready,
  input  logic                                      commit_flush,
  output logic [WB_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0] wb_phyf_id,
  output logic [WB_WIDTH-1:0][REG_DATA_WIDTH-1:0]   wb_phyf_data,
  output logic [WB_WIDTH-1:0]                       wb_phyf_we,
  output logic [15:0]                               wb_conflict_cnt
);

  localparam int PTR_W = (EXU_NUM > 1) ? $clog2(EXU_NUM) : 1;

  logic [PTR_W-1:0]                         rr_ptr_q, rr_ptr_d;
  logic [EXU_NUM-1:0]                       rot_valid, grant_rot, grant;
  logic [WB_WIDTH-1:0][PTR_W-1:0]           slot_idx;
  logic [WB_WIDTH-1:0]                      slot_used;
  logic [PTR_W-1:0]                         last_idx;
  logic [WB_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0] id_q, id_d;
  logic [WB_WIDTH-1:0][REG_DATA_WIDTH-1:0]   data_q, data_d;
  logic [WB_WIDTH-1:0]                      we_q;
  logic [15:0]                              cnt_q, cnt_d;
  int                                       valid_cnt;

  // Rotate so that the picker always scans from index 0 = rr_ptr.
  always_comb begin
    rot_valid = '0;
    for (int j = 0; j < EXU_NUM; j++) begin
      rot_valid[j] = exu_wb_valid[wrap_idx(int'(rr_ptr_q), j, EXU_NUM)];
    end
  end

  wb_rr_picker #(
    .N     (EXU_NUM),
    .W     (WB_WIDTH),
    .PTR_W (PTR_W)
  ) u_picker (
    .rot_valid (rot_valid),
    .grant_rot (grant_rot),
    .slot_idx  (slot_idx),
    .slot_used (slot_used),
    .last_idx  (last_idx)
  );

  // Map grants and slot sources back to absolute requester indices.
  always_comb begin
    grant  = '0;
    id_d   = '0;
    data_d = '0;
    for (int j = 0; j < EXU_NUM; j++) begin
      if (grant_rot[j]) grant[wrap_idx(int'(rr_ptr_q), j, EXU_NUM)] = 1'b1;
    end
    for (int k = 0; k < WB_WIDTH; k++) begin
      id_d[k]   = exu_wb_id[wrap_idx(int'(rr_ptr_q), int'(slot_idx[k]), EXU_NUM)];
      data_d[k] = exu_wb_data[wrap_idx(int'(rr_ptr_q), int'(slot_idx[k]), EXU_NUM)];
    end
    rr_ptr_d = PTR_W'(wrap_idx(int'(rr_ptr_q), int'(last_idx) + 1, EXU_NUM));
  end

  // Oversubscription detection and saturating increment.
  always_comb begin
    valid_cnt = 0;
    for (int j = 0; j < EXU_NUM; j++) valid_cnt = valid_cnt + int'(exu_wb_valid[j]);
    cnt_d = cnt_q;
    if ((valid_cnt > WB_WIDTH) && (cnt_q != CONFLICT_MAX)) cnt_d = cnt_q + 16'd1;
  end

  // Flush and reset both suppress the handshake so dropped requests never commit.
  assign exu_wb_ready = (rst || commit_flush) ? '0 : grant;

  // Slot registers: we pulses per grant, id/data load only for used slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= '0;
      id_q   <= '0;
      data_q <= '0;
    end else if (commit_flush) begin
      we_q <= '0;
    end else begin
      for (int k = 0; k < WB_WIDTH; k++) begin
        we_q[k] <= slot_used[k];
        if (slot_used[k]) begin
          id_q[k]   <= id_d[k];
          data_q[k] <= data_d[k];
        end
      end
    end
  end

  // Pointer advances past the last granted requester; flush restarts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               rr_ptr_q <= '0;
    else if (commit_flush) rr_ptr_q <= '0;
    else if (slot_used[0]) rr_ptr_q <= rr_ptr_d;
  end

  // Conflict counter keeps counting through flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign wb_phyf_we      = we_q;
  assign wb_phyf_id      = id_q;
  assign wb_phyf_data    = data_q;
  assign wb_conflict_cnt = cnt_q;

endmodule
